// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   - LS_*  : 3-bit load/store width codes from the ALU decoder
//   - FLT_* : 2-bit completion fault codes
//   - state_e : controller FSM states
package lsu_pkg;

    localparam logic [2:0] LS_W  = 3'b000;  // word
    localparam logic [2:0] LS_B  = 3'b001;  // byte signed / sb
    localparam logic [2:0] LS_H  = 3'b010;  // half signed / sh
    localparam logic [2:0] LS_BU = 3'b011;  // byte unsigned (load only)
    localparam logic [2:0] LS_HU = 3'b100;  // half unsigned (load only)

    localparam logic [1:0] FLT_OK  = 2'b00;
    localparam logic [1:0] FLT_MIS = 2'b01;
    localparam logic [1:0] FLT_ILL = 2'b10;
    localparam logic [1:0] FLT_TMO = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: word-addressed, single-outstanding data-memory bus.
//   mem_req   : request (master -> slave)
//   mem_we    : write enable
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables
//   mem_wdata : lane-replicated store data
//   mem_rdata : read data, valid with mem_ack (slave -> master)
//   mem_ack   : completes the current request
interface lsu_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   i_is_store, i_load_store, i_addr_lo, i_wdata : incoming request
//   i_ld_code, i_ld_off, i_mem_rdata             : latched load shape + bus read data
//   o_be, o_wdata        : byte enables and lane-replicated store data
//   o_misaligned, o_illegal : request check flags (illegal has priority at the user)
//   o_ld_data            : extracted, sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_load_store,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_code,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic        o_illegal,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_load_store)
            LS_W: begin
                o_be         = 4'b1111;
                o_misaligned = (i_addr_lo != 2'b00);
            end
            LS_B, LS_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            LS_H, LS_HU: begin
                o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            default: o_illegal = 1'b1;
        endcase
        // Unsigned widths have no store counterpart.
        if (i_is_store && (i_load_store == LS_BU || i_load_store == LS_HU)) begin
            o_illegal = 1'b1;
        end
    end

    always_comb begin
        case (i_ld_off)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_ld_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (i_ld_code)
            LS_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            LS_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            LS_BU:   o_ld_data = {24'h0, w_byte};
            LS_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller (IDLE -> REQ -> DONE), all outputs registered.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_start              : request strobe, sampled in IDLE only
//   i_is_store, i_load_store, i_addr, i_wdata : request
//   o_busy, o_done, o_fault, o_rdata          : status / load result
//   mem                  : data-memory bus (lsu_ctrl_if.master)
// Build option: define LSU_TIMEOUT_EN to abort a REQ after TIMEOUT_CYCLES cycles without ack.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_is_store,
    input  logic [2:0]  i_load_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_fault,
    output logic [31:0] o_rdata,
    lsu_ctrl_if.master  mem
);

    // The counter is 8 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..256");
    end

    state_e      r_state, w_state_d;
    logic        r_busy, w_busy_d;
    logic        r_done, w_done_d;
    logic [1:0]  r_fault, w_fault_d;
    logic [31:0] r_rdata, w_rdata_d;
    logic        r_mem_req, w_mem_req_d;
    logic        r_mem_we, w_mem_we_d;
    logic [31:0] r_mem_addr, w_mem_addr_d;
    logic [3:0]  r_mem_be, w_mem_be_d;
    logic [31:0] r_mem_wdata, w_mem_wdata_d;
    logic [2:0]  r_code, w_code_d;
    logic [1:0]  r_off, w_off_d;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_mis;
    logic        w_ill;
    logic [31:0] w_ld_data;
    logic        w_tmo;

    lsu_align u_align (
        .i_is_store   (i_is_store),
        .i_load_store (i_load_store),
        .i_addr_lo    (i_addr[1:0]),
        .i_wdata      (i_wdata),
        .i_ld_code    (r_code),
        .i_ld_off     (r_off),
        .i_mem_rdata  (mem.mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_mis),
        .o_illegal    (w_ill),
        .o_ld_data    (w_ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= 8'd0;
        end else if (r_state != StReq) begin
            r_cnt <= 8'd0;  // cleared on every REQ entry
        end else if (!mem.mem_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Ack in the same cycle wins over timeout.
    assign w_tmo = (r_state == StReq) && !mem.mem_ack
                   && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= FLT_OK;
            r_rdata     <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_code      <= LS_W;
            r_off       <= 2'b00;
        end else begin
            r_state     <= w_state_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_fault     <= w_fault_d;
            r_rdata     <= w_rdata_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_be    <= w_mem_be_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_code      <= w_code_d;
            r_off       <= w_off_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (i_start) w_state_d = (w_ill || w_mis) ? StDone : StReq;
            StReq:  if (mem.mem_ack || w_tmo) w_state_d = StDone;
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Next registered outputs
    always_comb begin
        w_busy_d      = r_busy;
        w_done_d      = 1'b0;
        w_fault_d     = r_fault;
        w_rdata_d     = r_rdata;
        w_mem_req_d   = r_mem_req;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_be_d    = r_mem_be;
        w_mem_wdata_d = r_mem_wdata;
        w_code_d      = r_code;
        w_off_d       = r_off;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (w_ill) begin
                        w_done_d  = 1'b1;
                        w_fault_d = FLT_ILL;
                    end else if (w_mis) begin
                        w_done_d  = 1'b1;
                        w_fault_d = FLT_MIS;
                    end else begin
                        w_busy_d      = 1'b1;
                        w_mem_req_d   = 1'b1;
                        w_mem_we_d    = i_is_store;
                        w_mem_addr_d  = {i_addr[31:2], 2'b00};
                        w_mem_be_d    = w_be;
                        w_mem_wdata_d = w_wdata;
                        w_code_d      = i_load_store;
                        w_off_d       = i_addr[1:0];
                    end
                end
            end
            StReq: begin
                if (mem.mem_ack || w_tmo) begin
                    w_busy_d    = 1'b0;
                    w_done_d    = 1'b1;
                    w_mem_req_d = 1'b0;
                    w_fault_d   = mem.mem_ack ? FLT_OK : FLT_TMO;
                    if (mem.mem_ack && !r_mem_we) w_rdata_d = w_ld_data;
                end
            end
            default: ;
        endcase
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_fault       = r_fault;
    assign o_rdata       = r_rdata;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_be    = r_mem_be;
    assign mem.mem_wdata = r_mem_wdata;

endmodule
